// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU-control stage: MIPS opcode/funct fields, ALU function codes,
// mul/div op codes and the sequencing FSM state type.
package alu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_OR   = 4'b1101;
  localparam logic [3:0] ALU_NOR  = 4'b1110;
  localparam logic [3:0] ALU_XOR  = 4'b1111;

  localparam logic [1:0] MD_NONE  = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_MULTU = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_func_lut.sv
// Combinational {opcode,funct} -> {ALU code, mul/div op, unsigned qualifier, illegal flag}.
// Unlisted encodings leave the code at 0000 and no mul/div op, so they can pass as plain ops.
module alu_func_lut
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int FUNC_W   = 4
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [FUNCT_W-1:0]  i_funct,
  output logic [FUNC_W-1:0]   o_func,
  output logic [1:0]          o_md_op,
  output logic                o_md_uns,
  output logic                o_illegal
);

  logic [3:0] code;

  always_comb begin
    code      = ALU_NOP;
    o_md_op   = MD_NONE;
    o_md_uns  = 1'b0;
    o_illegal = 1'b0;
    if (i_opcode == OPCODE_W'(OP_RTYPE)) begin
      case (i_funct)
        FUNCT_W'(FN_ADD):   code = ALU_ADD;
        FUNCT_W'(FN_SUB):   code = ALU_SUB;
        FUNCT_W'(FN_AND):   code = ALU_AND;
        FUNCT_W'(FN_OR):    code = ALU_OR;
        FUNCT_W'(FN_NOR):   code = ALU_NOR;
        FUNCT_W'(FN_XOR):   code = ALU_XOR;
        FUNCT_W'(FN_SLL):   code = ALU_SLL;
        FUNCT_W'(FN_SRL):   code = ALU_SRL;
        FUNCT_W'(FN_SRA):   code = ALU_SRA;
        FUNCT_W'(FN_SLT):   code = ALU_SLT;
        FUNCT_W'(FN_SLTU):  code = ALU_SLTU;
        FUNCT_W'(FN_MULT):  o_md_op = MD_MULT;
        FUNCT_W'(FN_MULTU): o_md_op = MD_MULTU;
        FUNCT_W'(FN_DIV):   o_md_op = MD_DIV;
        FUNCT_W'(FN_DIVU): begin
          o_md_op  = MD_DIV;
          o_md_uns = 1'b1;
        end
        default:            o_illegal = 1'b1;
      endcase
    end else begin
      // I/J types ignore funct entirely
      case (i_opcode)
        OPCODE_W'(OP_ADDI),
        OPCODE_W'(OP_LW),
        OPCODE_W'(OP_SW):    code = ALU_ADD;
        OPCODE_W'(OP_BEQ),
        OPCODE_W'(OP_BNE):   code = ALU_SUB;
        OPCODE_W'(OP_ANDI):  code = ALU_AND;
        OPCODE_W'(OP_ORI):   code = ALU_OR;
        OPCODE_W'(OP_XORI):  code = ALU_XOR;
        OPCODE_W'(OP_SLTI):  code = ALU_SLT;
        OPCODE_W'(OP_SLTIU): code = ALU_SLTU;
        OPCODE_W'(OP_J):     code = ALU_NOP;
        default:             o_illegal = 1'b1;
      endcase
    end
  end

  assign o_func = FUNC_W'(code);

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU-control stage: 1-cycle decode for plain ops, MUL/DIV_CYCLES iterations for mul/div.
// Stalls upstream (o_ready=0) while iterating or while a result is held; `ALU_ILLEGAL_TRAP_EN adds o_illegal.
module alu_decode_stage
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int FUNCT_W    = 6,
  parameter int FUNC_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [FUNCT_W-1:0]  i_funct,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [FUNC_W-1:0]   o_alu_func,
  output logic [1:0]          o_md_op,
  output logic                o_md_uns,
  output logic                o_md_start,
  output logic                o_busy
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic                o_illegal
`endif
);

  localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

  logic [FUNC_W-1:0] lut_func;
  logic [1:0]        lut_md_op;
  logic              lut_md_uns;
  logic              lut_illegal;

  alu_func_lut #(
    .OPCODE_W (OPCODE_W),
    .FUNCT_W  (FUNCT_W),
    .FUNC_W   (FUNC_W)
  ) u_lut (
    .i_opcode  (i_opcode),
    .i_funct   (i_funct),
    .o_func    (lut_func),
    .o_md_op   (lut_md_op),
    .o_md_uns  (lut_md_uns),
    .o_illegal (lut_illegal)
  );

  state_e            state_q,    state_d;
  logic              valid_q,    valid_d;
  logic [FUNC_W-1:0] func_q,     func_d;
  logic [1:0]        md_op_q,    md_op_d;
  logic              md_uns_q,   md_uns_d;
  logic              md_start_q, md_start_d;
  logic              busy_q,     busy_d;
  logic              illegal_q,  illegal_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              accept;

  // Reset and flush both block acceptance so upstream never sees a lost handshake.
  assign o_ready = !i_rst && !i_flush && (state_q != BUSY) && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    func_d     = func_q;
    md_op_d    = md_op_q;
    md_uns_d   = md_uns_q;
    md_start_d = 1'b0;
    busy_d     = busy_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;
    if (i_flush) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      func_d    = '0;
      md_op_d   = MD_NONE;
      md_uns_d  = 1'b0;
      busy_d    = 1'b0;
      illegal_d = 1'b0;
      cnt_d     = '0;
    end else if (state_q == BUSY) begin
      if (cnt_q == '0) begin
        state_d = DONE;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (accept) begin
      md_op_d   = lut_md_op;
      md_uns_d  = lut_md_uns;
      illegal_d = lut_illegal;
      if (lut_md_op != MD_NONE) begin
        state_d    = BUSY;
        valid_d    = 1'b0;
        func_d     = '0;
        md_start_d = 1'b1;
        busy_d     = 1'b1;
        cnt_d      = (lut_md_op == MD_DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
      end else begin
        state_d = IDLE;
        valid_d = 1'b1;
        func_d  = lut_func;
      end
    end else if (valid_q && i_ready) begin
      // Result drained with nothing behind it: clear so stale fields never linger.
      state_d   = IDLE;
      valid_d   = 1'b0;
      func_d    = '0;
      md_op_d   = MD_NONE;
      md_uns_d  = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      func_q     <= '0;
      md_op_q    <= MD_NONE;
      md_uns_q   <= 1'b0;
      md_start_q <= 1'b0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      func_q     <= func_d;
      md_op_q    <= md_op_d;
      md_uns_q   <= md_uns_d;
      md_start_q <= md_start_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_alu_func = func_q;
  assign o_md_op    = md_op_q;
  assign o_md_uns   = md_uns_q;
  assign o_md_start = md_start_q;
  assign o_busy     = busy_q;

`ifdef ALU_ILLEGAL_TRAP_EN
  assign o_illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_alu_decode_stage;

  localparam int MULN = 4;
  localparam int DIVN = 32;

  logic       i_clk = 1'b0;
  logic       i_rst, i_flush, i_valid, i_ready;
  logic [5:0] i_opcode, i_funct;
  logic       o_ready, o_valid, o_md_uns, o_md_start, o_busy;
  logic [3:0] o_alu_func;
  logic [1:0] o_md_op;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic       o_illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  alu_decode_stage #(
    .OPCODE_W(6), .FUNCT_W(6), .FUNC_W(4), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct(i_funct), .o_valid(o_valid), .i_ready(i_ready),
    .o_alu_func(o_alu_func), .o_md_op(o_md_op), .o_md_uns(o_md_uns),
    .o_md_start(o_md_start), .o_busy(o_busy)
`ifdef ALU_ILLEGAL_TRAP_EN
    , .o_illegal(o_illegal)
`endif
  );

  // Reference table of listed encodings: rt=1 means funct matters (R-type).
  typedef struct {
    bit         rt;
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic [1:0] md;
    logic       uns;
  } ent_t;
  ent_t tbl[$];

  typedef struct {
    logic [3:0] func;
    logic [1:0] md;
    logic       uns;
    logic       ill;
    bit         is_md;
    int         scyc;
    int         vcyc;
  } exp_t;

  function automatic ent_t mk(bit rt, logic [5:0] op, logic [5:0] fn, logic [3:0] code,
                              logic [1:0] md, logic uns);
    ent_t e;
    e.rt = rt; e.op = op; e.fn = fn; e.code = code; e.md = md; e.uns = uns;
    return e;
  endfunction

  task automatic build_table();
    tbl.push_back(mk(1, 6'h00, 6'h20, 4'b1000, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h22, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h24, 4'b1100, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h25, 4'b1101, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h27, 4'b1110, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h26, 4'b1111, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h00, 4'b0000, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h02, 4'b0001, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h03, 4'b0010, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h2A, 4'b0100, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h2B, 4'b0101, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 6'h18, 4'b0000, 2'b01, 0));
    tbl.push_back(mk(1, 6'h00, 6'h19, 4'b0000, 2'b10, 0));
    tbl.push_back(mk(1, 6'h00, 6'h1A, 4'b0000, 2'b11, 0));
    tbl.push_back(mk(1, 6'h00, 6'h1B, 4'b0000, 2'b11, 1));
    tbl.push_back(mk(0, 6'h08, 6'h00, 4'b1000, 2'b00, 0));
    tbl.push_back(mk(0, 6'h23, 6'h00, 4'b1000, 2'b00, 0));
    tbl.push_back(mk(0, 6'h2B, 6'h00, 4'b1000, 2'b00, 0));
    tbl.push_back(mk(0, 6'h04, 6'h00, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 6'h05, 6'h00, 4'b1001, 2'b00, 0));
    tbl.push_back(mk(0, 6'h0C, 6'h00, 4'b1100, 2'b00, 0));
    tbl.push_back(mk(0, 6'h0D, 6'h00, 4'b1101, 2'b00, 0));
    tbl.push_back(mk(0, 6'h0E, 6'h00, 4'b1111, 2'b00, 0));
    tbl.push_back(mk(0, 6'h0A, 6'h00, 4'b0100, 2'b00, 0));
    tbl.push_back(mk(0, 6'h0B, 6'h00, 4'b0101, 2'b00, 0));
    tbl.push_back(mk(0, 6'h02, 6'h00, 4'b0000, 2'b00, 0));
  endtask

  function automatic exp_t ref_decode(logic [5:0] op, logic [5:0] fn);
    exp_t r;
    r.func = 4'b0000; r.md = 2'b00; r.uns = 1'b0; r.ill = 1'b1;
    r.is_md = 0; r.scyc = 0; r.vcyc = 0;
    foreach (tbl[i]) begin
      if (tbl[i].op == op && (!tbl[i].rt || tbl[i].fn == fn)) begin
        r.func = tbl[i].code; r.md = tbl[i].md; r.uns = tbl[i].uns; r.ill = 1'b0;
        r.is_md = (tbl[i].md != 2'b00);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_opcode = 6'h00; i_funct = 6'h00;
    tick(); tick();
    i_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    i_opcode = 6'h00; i_funct = 6'h20;
    tick(); tick();
    n_checks++;
    if ({o_valid, o_alu_func, o_md_op, o_md_uns, o_md_start, o_busy, o_ready} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b f=%b md=%b u=%b s=%b b=%b r=%b, want all 0",
               o_valid, o_alu_func, o_md_op, o_md_uns, o_md_start, o_busy, o_ready);
    end
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: got %b want 1", o_ready);
    end
  endtask

  task automatic test_add_back_to_back();
    do_reset();
    i_ready = 1'b1; i_valid = 1'b1; i_opcode = 6'h00; i_funct = 6'h20;
    tick();
    n_checks++;
    if ({o_valid, o_alu_func} !== 5'b1_1000) begin
      n_fail++; $display("FAIL add_result: got v=%b f=%b want v=1 f=1000", o_valid, o_alu_func);
    end
    i_opcode = 6'h08; i_funct = 6'($urandom);
    tick();
    n_checks++;
    if ({o_valid, o_alu_func} !== 5'b1_1000) begin
      n_fail++; $display("FAIL addi_b2b: got v=%b f=%b want v=1 f=1000", o_valid, o_alu_func);
    end
    i_valid = 1'b0;
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_drain: got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_hold_sub();
    do_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_opcode = 6'h00; i_funct = 6'h22;
    tick();
    i_funct = 6'h24;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_checks++;
      if ({o_valid, o_alu_func, o_ready} !== 6'b1_1001_0) begin
        n_fail++;
        $display("FAIL sub_hold c%0d: got v=%b f=%b r=%b want v=1 f=1001 r=0",
                 k, o_valid, o_alu_func, o_ready);
      end
      tick();
    end
    i_ready = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, o_alu_func, o_ready} !== 6'b1_1001_1) begin
      n_fail++;
      $display("FAIL sub_release: got v=%b f=%b r=%b want v=1 f=1001 r=1", o_valid, o_alu_func, o_ready);
    end
    tick();
    i_valid = 1'b0;
    n_checks++;
    if ({o_valid, o_alu_func} !== 5'b1_1100) begin
      n_fail++; $display("FAIL sub_next_and: got v=%b f=%b want v=1 f=1100", o_valid, o_alu_func);
    end
    tick();
  endtask

  task automatic test_div_latency();
    int busy_cnt;
    do_reset();
    i_ready = 1'b1; i_valid = 1'b1; i_opcode = 6'h00; i_funct = 6'h1A;
    tick();
    i_valid = 1'b0;
    #1;
    n_checks++;
    if ({o_md_start, o_busy, o_valid, o_md_op, o_ready} !== 6'b1_1_0_11_0) begin
      n_fail++;
      $display("FAIL div_start: got s=%b b=%b v=%b md=%b r=%b want s=1 b=1 v=0 md=11 r=0",
               o_md_start, o_busy, o_valid, o_md_op, o_ready);
    end
    busy_cnt = o_busy ? 1 : 0;
    for (int k = 2; k <= DIVN; k++) begin
      tick();
      n_checks++;
      if ({o_md_start, o_busy, o_valid} !== 3'b010) begin
        n_fail++;
        $display("FAIL div_busy c%0d: got s=%b b=%b v=%b want s=0 b=1 v=0", k, o_md_start, o_busy, o_valid);
      end
      if (o_busy) busy_cnt++;
    end
    tick();
    n_checks++;
    if ({o_valid, o_busy, o_md_op, o_md_uns, o_alu_func, busy_cnt} !==
        {1'b1, 1'b0, 2'b11, 1'b0, 4'b0000, 32'(DIVN)}) begin
      n_fail++;
      $display("FAIL div_done: got v=%b b=%b md=%b u=%b f=%b busy_cycles=%0d want v=1 b=0 md=11 u=0 f=0000 busy_cycles=%0d",
               o_valid, o_busy, o_md_op, o_md_uns, o_alu_func, busy_cnt, DIVN);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL div_drain: got v=%b want 0", o_valid);
    end
  endtask

  task automatic test_flush_mult();
    int seen;
    do_reset();
    i_ready = 1'b1; i_valid = 1'b1; i_opcode = 6'h00; i_funct = 6'h18;
    tick();
    i_valid = 1'b0;
    tick();
    i_flush = 1'b1; i_valid = 1'b1; i_funct = 6'h20;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_valid, o_ready, o_md_op} !== 5'b0_0_1_00) begin
      n_fail++;
      $display("FAIL flush_mult: got b=%b v=%b r=%b md=%b want b=0 v=0 r=1 md=00", o_busy, o_valid, o_ready, o_md_op);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_valid || o_busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL flush_no_valid: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_reset_in_done();
    int waited;
    do_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_opcode = 6'h00; i_funct = 6'h19;
    tick();
    i_valid = 1'b0;
    waited = 0;
    while (!o_valid && waited < 20) begin
      tick(); waited++;
    end
    n_checks++;
    if ({o_valid, o_md_op, waited} !== {1'b1, 2'b10, 32'(MULN)}) begin
      n_fail++;
      $display("FAIL multu_done: got v=%b md=%b after %0d cycles want v=1 md=10 after %0d",
               o_valid, o_md_op, waited, MULN);
    end
    i_rst = 1'b1;
    tick();
    n_checks++;
    if ({o_valid, o_alu_func, o_md_op, o_md_uns, o_md_start, o_busy, o_ready} !== 11'b0) begin
      n_fail++;
      $display("FAIL rst_in_done: got v=%b f=%b md=%b u=%b s=%b b=%b r=%b want all 0",
               o_valid, o_alu_func, o_md_op, o_md_uns, o_md_start, o_busy, o_ready);
    end
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_done_ready: got %b want 1", o_ready);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    i_ready = 1'b1; i_valid = 1'b1; i_opcode = 6'h3F; i_funct = 6'h20;
    tick();
    n_checks++;
    if ({o_valid, o_alu_func, o_md_op} !== 7'b1_0000_00) begin
      n_fail++; $display("FAIL unlisted: got v=%b f=%b md=%b want v=1 f=0000 md=00", o_valid, o_alu_func, o_md_op);
    end
`ifdef ALU_ILLEGAL_TRAP_EN
    n_checks++;
    if (o_illegal !== 1'b1) begin
      n_fail++; $display("FAIL unlisted_illegal: got %b want 1", o_illegal);
    end
`endif
    i_opcode = 6'h0B;
    tick();
    i_valid = 1'b0;
    n_checks++;
    if ({o_valid, o_alu_func} !== 5'b1_0101) begin
      n_fail++; $display("FAIL sltiu: got v=%b f=%b want v=1 f=0101", o_valid, o_alu_func);
    end
`ifdef ALU_ILLEGAL_TRAP_EN
    n_checks++;
    if (o_illegal !== 1'b0) begin
      n_fail++; $display("FAIL sltiu_illegal: got %b want 0", o_illegal);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   cyc;
    bit   ev, eb, es, er, hs, acc;
    do_reset();
    cyc = 0;
    for (int c = 0; c < 1500; c++) begin
      ev = (q.size() > 0) && (cyc >= q[0].vcyc);
      eb = (q.size() > 0) && q[0].is_md && (cyc < q[0].vcyc);
      es = (q.size() > 0) && q[0].is_md && (cyc == q[0].scyc);
      n_checks++;
      if ({o_valid, o_busy, o_md_start} !== {ev, eb, es}) begin
        n_fail++;
        $display("FAIL rnd_status cyc%0d: got v=%b b=%b s=%b want v=%b b=%b s=%b",
                 cyc, o_valid, o_busy, o_md_start, ev, eb, es);
      end
      if (ev) begin
        n_checks++;
        if ({o_alu_func, o_md_op, o_md_uns} !== {q[0].func, q[0].md, q[0].uns}) begin
          n_fail++;
          $display("FAIL rnd_data cyc%0d: got f=%b md=%b u=%b want f=%b md=%b u=%b",
                   cyc, o_alu_func, o_md_op, o_md_uns, q[0].func, q[0].md, q[0].uns);
        end
`ifdef ALU_ILLEGAL_TRAP_EN
        n_checks++;
        if (o_illegal !== q[0].ill) begin
          n_fail++; $display("FAIL rnd_illegal cyc%0d: got %b want %b", cyc, o_illegal, q[0].ill);
        end
`endif
      end
      // New stimulus for this cycle.
      i_valid = ($urandom_range(3) != 0);
      i_ready = ($urandom_range(3) != 0);
      i_flush = ($urandom_range(99) < 2);
      if ($urandom_range(4) == 0) begin
        i_opcode = 6'($urandom); i_funct = 6'($urandom);
      end else begin
        e.is_md = 0;
        i_opcode = tbl[$urandom_range(tbl.size() - 1)].op;
        i_funct = 6'($urandom);
        foreach (tbl[i]) if (tbl[i].op == i_opcode && tbl[i].rt && $urandom_range(1) == 0) begin
          i_funct = tbl[i].fn;
        end
      end
      #1;
      er = !i_flush && !eb && (!ev || i_ready);
      n_checks++;
      if (o_ready !== er) begin
        n_fail++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, o_ready, er);
      end
      hs  = ev && i_ready && !i_flush;
      acc = i_valid && er;
      if (i_flush) q.delete();
      if (hs) void'(q.pop_front());
      if (acc) begin
        e = ref_decode(i_opcode, i_funct);
        e.scyc = cyc + 1;
        e.vcyc = e.is_md ? cyc + 1 + ((e.md == 2'b11) ? DIVN : MULN) : cyc + 1;
        q.push_back(e);
      end
      tick();
      cyc++;
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_table();
    test_reset();
    test_add_back_to_back();
    test_hold_sub();
    test_div_latency();
    test_flush_mult();
    test_reset_in_done();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
